// File: rtl/user_sw_event_gen_pkg.sv
// Shared types and constants for the user switch event generator.
package user_sw_pkg;

  // Per-channel press tracking state.
  typedef enum logic [1:0] {
    StIdle,
    StPressed,
    StLong
  } sw_state_e;

  // Hold/repeat counter width; thresholds up to 65535 ticks fit.
  localparam int unsigned CntWidth = 16;

  localparam int unsigned DefaultLongMs   = 1000;
  localparam int unsigned DefaultRepeatMs = 200;

  typedef logic [CntWidth-1:0] cnt_t;

  // Counter value that matches on the tick which completes a period of ms ticks.
  function automatic cnt_t period_last(input int unsigned ms);
    return cnt_t'(ms - 1);
  endfunction

endpackage

// File: rtl/user_sw_event_gen_if.sv
// Bundle of tick, switch inputs and event outputs of the switch event generator.
interface user_sw_event_gen_if #(
  parameter int unsigned pChannels = 4
);

  logic                 iCke;
  logic [pChannels-1:0] iUserPushSw;
  logic [3:0]           iUserSlideSw;

  logic [pChannels-1:0] oPress;
  logic [pChannels-1:0] oRelease;
  logic [pChannels-1:0] oLongPress;
  logic [pChannels-1:0] oRepeat;
  logic [pChannels-1:0] oHeld;
  logic                 oSlideChg;
  logic [3:0]           oSlideSw;

  // Stimulus side: drives the tick and switch levels, observes events.
  modport master (
    output iCke,
    output iUserPushSw,
    output iUserSlideSw,
    input  oPress,
    input  oRelease,
    input  oLongPress,
    input  oRepeat,
    input  oHeld,
    input  oSlideChg,
    input  oSlideSw
  );

  // Event generator side.
  modport slave (
    input  iCke,
    input  iUserPushSw,
    input  iUserSlideSw,
    output oPress,
    output oRelease,
    output oLongPress,
    output oRepeat,
    output oHeld,
    output oSlideChg,
    output oSlideSw
  );

endinterface

// File: rtl/user_sw_event_ch.sv
// One push-switch channel: edge detection, hold timing and event pulses.
module user_sw_event_ch
  import user_sw_pkg::*;
#(
  parameter int unsigned pLongMs   = DefaultLongMs,
  parameter int unsigned pRepeatMs = DefaultRepeatMs
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic cke_i,
  input  logic push_i,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o,
  output logic held_o
);

  localparam cnt_t LongLast   = period_last(pLongMs);
  localparam cnt_t RepeatLast = period_last(pRepeatMs);

  sw_state_e state_q, state_d;
  cnt_t      cnt_q, cnt_d;
  logic      prev_q;
  logic      press_q, press_d;
  logic      release_q, release_d;
  logic      long_q, long_d;
  logic      repeat_q, repeat_d;
  logic      held_q, held_d;

  logic press_edge;
  logic release_edge;
  logic long_hit;
  logic repeat_hit;

  assign press_edge   = push_i & ~prev_q;
  assign release_edge = ~push_i & prev_q;
  assign long_hit     = cke_i && (cnt_q == LongLast);
  assign repeat_hit   = cke_i && (cnt_q == RepeatLast);

  // Next state, counter and event pulses; release takes priority over any threshold.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (press_edge) begin
          state_d = StPressed;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      StPressed: begin
        if (release_edge) begin
          state_d   = StIdle;
          release_d = 1'b1;
        end else if (long_hit) begin
          state_d = StLong;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else if (cke_i) begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      StLong: begin
        if (release_edge) begin
          state_d   = StIdle;
          release_d = 1'b1;
        end else if (repeat_hit) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else if (cke_i) begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    held_d = (state_d != StIdle);
  end

  // State, previous level, counter and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      prev_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prev_q    <= push_i;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;
  assign held_o    = held_q;

endmodule

// File: rtl/user_sw_event_gen.sv
// User switch event generator: per-channel push events plus slide-switch change detect.
module user_sw_event_gen
  import user_sw_pkg::*;
#(
  parameter int unsigned pChannels = 4,
  parameter int unsigned pLongMs   = DefaultLongMs,
  parameter int unsigned pRepeatMs = DefaultRepeatMs
) (
  input logic              iSysClk,
  input logic              iSysRst,
  user_sw_event_gen_if.slave bus
);

  logic [pChannels-1:0] press;
  logic [pChannels-1:0] release_ev;
  logic [pChannels-1:0] long_ev;
  logic [pChannels-1:0] repeat_ev;
  logic [pChannels-1:0] held;

  logic [3:0] slide_q, slide_d;
  logic       slide_chg_q, slide_chg_d;

  for (genvar g = 0; g < pChannels; g++) begin : gen_ch
    user_sw_event_ch #(
      .pLongMs  (pLongMs),
      .pRepeatMs(pRepeatMs)
    ) u_ch (
      .clk_i    (iSysClk),
      .rst_ni   (iSysRst),
      .cke_i    (bus.iCke),
      .push_i   (bus.iUserPushSw[g]),
      .press_o  (press[g]),
      .release_o(release_ev[g]),
      .long_o   (long_ev[g]),
      .repeat_o (repeat_ev[g]),
      .held_o   (held[g])
    );
  end

  // Slide copy follows the input; a change pulses alongside the copy update.
  always_comb begin
    slide_d     = bus.iUserSlideSw;
    slide_chg_d = (slide_q != bus.iUserSlideSw);
  end

  // Slide copy and change pulse registers.
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      slide_q     <= '0;
      slide_chg_q <= 1'b0;
    end else begin
      slide_q     <= slide_d;
      slide_chg_q <= slide_chg_d;
    end
  end

  assign bus.oPress     = press;
  assign bus.oRelease   = release_ev;
  assign bus.oLongPress = long_ev;
  assign bus.oRepeat    = repeat_ev;
  assign bus.oHeld      = held;
  assign bus.oSlideChg  = slide_chg_q;
  assign bus.oSlideSw   = slide_q;

endmodule

// File: tb/tb_user_sw_event_gen.sv
// Self-checking bench for user_sw_event_gen (pLongMs=4, pRepeatMs=2, tick every 3 clocks).
module tb_user_sw_event_gen;

  localparam int NCh    = 4;
  localparam int LongMs = 4;
  localparam int RepMs  = 2;
  localparam int W      = 5 * NCh + 5;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  // Reference model: previous level, ticks held since press, last slide value.
  logic         m_prev[NCh];
  int           m_k[NCh];
  logic [3:0]   m_slide;
  logic [W-1:0] exp_vec;
  logic [3:0]   cur_slide;

  always #5 clk = ~clk;

  user_sw_event_gen_if #(.pChannels(NCh)) bus ();

  user_sw_event_gen #(
    .pChannels(NCh),
    .pLongMs  (LongMs),
    .pRepeatMs(RepMs)
  ) dut (
    .iSysClk(clk),
    .iSysRst(rst_n),
    .bus    (bus)
  );

  function automatic logic [W-1:0] dut_vec();
    return {bus.oPress, bus.oRelease, bus.oLongPress, bus.oRepeat, bus.oHeld,
            bus.oSlideChg, bus.oSlideSw};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCh; c++) begin
      m_prev[c] = 1'b0;
      m_k[c]    = 0;
    end
    m_slide = 4'b0000;
    exp_vec = '0;
  endtask

  // Drive one cycle of inputs, predict the outputs from the event rules, advance one clock.
  // Events: long press on the LongMs-th tick after the press, then a repeat every RepMs ticks.
  task automatic step(input logic [NCh-1:0] push, input logic [3:0] slide);
    logic           cke;
    logic [NCh-1:0] p, r, l, rp, h;
    cke = (cyc % 3 == 2);
    bus.iCke         = cke;
    bus.iUserPushSw  = push;
    bus.iUserSlideSw = slide;
    p = '0; r = '0; l = '0; rp = '0; h = '0;
    for (int c = 0; c < NCh; c++) begin
      if (push[c] && !m_prev[c]) begin
        p[c]   = 1'b1;
        m_k[c] = 0;
      end else if (!push[c] && m_prev[c]) begin
        r[c] = 1'b1;
      end else if (push[c] && cke) begin
        m_k[c] = m_k[c] + 1;
        if (m_k[c] == LongMs) l[c] = 1'b1;
        else if (m_k[c] > LongMs && ((m_k[c] - LongMs) % RepMs) == 0) rp[c] = 1'b1;
      end
      h[c]      = push[c];
      m_prev[c] = push[c];
    end
    exp_vec = {p, r, l, rp, h, (slide != m_slide), slide};
    m_slide = slide;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    bus.iCke         = 1'b0;
    bus.iUserPushSw  = '0;
    bus.iUserSlideSw = '0;
    cur_slide        = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== exp_vec) begin
      fails++;
      $display("FAIL reset_outputs: got %h want %h", dut_vec(), exp_vec);
    end
    rst_n = 1'b1;
    step(4'b0000, cur_slide);
    checks++;
    if (dut_vec() !== exp_vec) begin
      fails++;
      $display("FAIL idle_after_reset: got %h want %h", dut_vec(), exp_vec);
    end
  endtask

  task automatic test_short_press();
    int n_press = 0, n_rel = 0, n_long = 0, n_held = 0;
    for (int i = 0; i < 10; i++) begin
      step((i < 6) ? 4'b0001 : 4'b0000, cur_slide);
      checks++;
      if (dut_vec() !== exp_vec) begin
        fails++;
        $display("FAIL short_press cyc %0d: got %h want %h", cyc, dut_vec(), exp_vec);
      end
      n_press += int'(bus.oPress[0]);
      n_rel   += int'(bus.oRelease[0]);
      n_long  += int'(bus.oLongPress[0]);
      n_held  += int'(bus.oHeld[0]);
    end
    checks++;
    if (n_press != 1 || n_rel != 1 || n_long != 0 || n_held != 6) begin
      fails++;
      $display("FAIL short_press_counts: got press=%0d rel=%0d long=%0d held=%0d want 1 1 0 6",
               n_press, n_rel, n_long, n_held);
    end
  endtask

  task automatic test_long_hold();
    int ticks = 0, long_at = -1, n_rel = 0;
    int rep_at[$];
    step(4'b0010, cur_slide);
    checks++;
    if (dut_vec() !== exp_vec) begin
      fails++;
      $display("FAIL long_hold_press: got %h want %h", dut_vec(), exp_vec);
    end
    for (int i = 0; i < 100 && ticks < 9; i++) begin
      step(4'b0010, cur_slide);
      if (bus.iCke) ticks++;
      checks++;
      if (dut_vec() !== exp_vec) begin
        fails++;
        $display("FAIL long_hold cyc %0d: got %h want %h", cyc, dut_vec(), exp_vec);
      end
      if (bus.oLongPress[1]) long_at = ticks;
      if (bus.oRepeat[1]) rep_at.push_back(ticks);
    end
    step(4'b0000, cur_slide);
    n_rel = int'(bus.oRelease[1]);
    checks++;
    if (dut_vec() !== exp_vec) begin
      fails++;
      $display("FAIL long_hold_release: got %h want %h", dut_vec(), exp_vec);
    end
    checks++;
    if (long_at != 4 || rep_at.size() != 2 || n_rel != 1) begin
      fails++;
      $display("FAIL long_hold_timing: got long@%0d reps=%0d rel=%0d want long@4 reps=2 rel=1",
               long_at, rep_at.size(), n_rel);
    end else begin
      checks++;
      if (rep_at[0] != 6 || rep_at[1] != 8) begin
        fails++;
        $display("FAIL long_hold_repeat_ticks: got %0d,%0d want 6,8", rep_at[0], rep_at[1]);
      end
    end
  endtask

  task automatic test_release_on_threshold();
    int   ticks = 0;
    logic done  = 1'b0;
    step(4'b0100, cur_slide);
    for (int i = 0; i < 100 && !done; i++) begin
      if (ticks == 3 && (cyc % 3 == 2)) begin
        step(4'b0000, cur_slide);
        done = 1'b1;
        checks++;
        if (bus.oRelease !== 4'b0100 || bus.oLongPress !== 4'b0000 || bus.oHeld[2] !== 1'b0) begin
          fails++;
          $display("FAIL release_on_threshold: got rel=%b long=%b held=%b want 0100 0000 0",
                   bus.oRelease, bus.oLongPress, bus.oHeld[2]);
        end
      end else begin
        step(4'b0100, cur_slide);
        if (bus.iCke) ticks++;
      end
      checks++;
      if (dut_vec() !== exp_vec) begin
        fails++;
        $display("FAIL threshold_model cyc %0d: got %h want %h", cyc, dut_vec(), exp_vec);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(4'b0000, cur_slide);
      checks++;
      if (dut_vec() !== exp_vec) begin
        fails++;
        $display("FAIL threshold_idle cyc %0d: got %h want %h", cyc, dut_vec(), exp_vec);
      end
    end
  endtask

  task automatic test_simultaneous();
    step(4'b1111, cur_slide);
    checks++;
    if (bus.oPress !== 4'b1111 || dut_vec() !== exp_vec) begin
      fails++;
      $display("FAIL simultaneous_press: got press=%b vec=%h want 1111 %h",
               bus.oPress, dut_vec(), exp_vec);
    end
    step(4'b1111, cur_slide);
    checks++;
    if (bus.oPress !== 4'b0000 || bus.oHeld !== 4'b1111) begin
      fails++;
      $display("FAIL simultaneous_one_cycle: got press=%b held=%b want 0000 1111",
               bus.oPress, bus.oHeld);
    end
    step(4'b0000, cur_slide);
    checks++;
    if (bus.oRelease !== 4'b1111 || dut_vec() !== exp_vec) begin
      fails++;
      $display("FAIL simultaneous_release: got rel=%b vec=%h want 1111 %h",
               bus.oRelease, dut_vec(), exp_vec);
    end
  endtask

  task automatic test_slide();
    cur_slide = 4'b0000;
    step(4'b0000, cur_slide);
    cur_slide = 4'b0101;
    step(4'b0000, cur_slide);
    checks++;
    if (bus.oSlideChg !== 1'b1 || bus.oSlideSw !== 4'b0101) begin
      fails++;
      $display("FAIL slide_change: got chg=%b sw=%b want 1 0101", bus.oSlideChg, bus.oSlideSw);
    end
    step(4'b0000, cur_slide);
    checks++;
    if (bus.oSlideChg !== 1'b0 || bus.oSlideSw !== 4'b0101) begin
      fails++;
      $display("FAIL slide_one_cycle: got chg=%b sw=%b want 0 0101", bus.oSlideChg, bus.oSlideSw);
    end
  endtask

  task automatic test_reset_mid_long();
    int ticks = 0;
    step(4'b1000, cur_slide);
    for (int i = 0; i < 100 && ticks < 5; i++) begin
      step(4'b1000, cur_slide);
      if (bus.iCke) ticks++;
    end
    checks++;
    if (bus.oHeld[3] !== 1'b1 || dut_vec() !== exp_vec) begin
      fails++;
      $display("FAIL reset_mid_long_setup: got %h want %h", dut_vec(), exp_vec);
    end
    #2;
    rst_n    = 1'b0;
    bus.iCke = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== exp_vec) begin
      fails++;
      $display("FAIL reset_async_clear: got %h want %h", dut_vec(), exp_vec);
    end
    cur_slide        = 4'b0110;
    bus.iUserSlideSw = cur_slide;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== exp_vec) begin
      fails++;
      $display("FAIL reset_hold_no_release: got %h want %h", dut_vec(), exp_vec);
    end
    rst_n = 1'b1;
    step(4'b1000, cur_slide);
    checks++;
    if (bus.oPress !== 4'b1000 || bus.oRelease !== 4'b0000 || bus.oSlideChg !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_press: got press=%b rel=%b chg=%b want 1000 0000 1",
               bus.oPress, bus.oRelease, bus.oSlideChg);
    end
    step(4'b1000, cur_slide);
    checks++;
    if (bus.oPress !== 4'b0000 || bus.oSlideChg !== 1'b0 || dut_vec() !== exp_vec) begin
      fails++;
      $display("FAIL reset_release_settle: got %h want %h", dut_vec(), exp_vec);
    end
    step(4'b0000, cur_slide);
    checks++;
    if (dut_vec() !== exp_vec) begin
      fails++;
      $display("FAIL reset_release_drop: got %h want %h", dut_vec(), exp_vec);
    end
  endtask

  task automatic test_random();
    logic [NCh-1:0] push = '0;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < NCh; c++)
        if ($urandom_range(11) == 0) push[c] = ~push[c];
      if ($urandom_range(7) == 0) cur_slide = 4'($urandom);
      step(push, cur_slide);
      checks++;
      if (dut_vec() !== exp_vec) begin
        fails++;
        $display("FAIL random cyc %0d: got %h want %h", cyc, dut_vec(), exp_vec);
      end
      checks++;
      if ((bus.oLongPress & bus.oRepeat) !== 4'b0000) begin
        fails++;
        $display("FAIL random_long_repeat_overlap cyc %0d: got %b want 0000", cyc,
                 bus.oLongPress & bus.oRepeat);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, cur_slide);
      checks++;
      if (dut_vec() !== exp_vec) begin
        fails++;
        $display("FAIL random_drain cyc %0d: got %h want %h", cyc, dut_vec(), exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_hold();
    test_release_on_threshold();
    test_simultaneous();
    test_slide();
    test_reset_mid_long();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
